// File: rtl/lut_loader.sv
// Branch-target table loaded from a 3-byte-per-entry byte stream; combinational lookup by label.
// Latency: a table write lands on the edge of the last frame byte, and the new value is visible the following cycle.
// Backpressure: in_ready is high while loading and drops in S_DONE until clear or reset.
// Ports: clk, reset (sync, active-high), clear; stream in_data/in_valid/in_last/in_ready;
//        lookup label -> next_pc; status load_done, err (sticky), entry_count (saturating).
module lut_loader #(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  input  logic [7:0]      label,
  output logic [PC_W-1:0] next_pc,
  output logic            load_done,
  output logic            err,
  output logic [6:0]      entry_count
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {S_LABEL, S_HI, S_LO, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        label_q;
  logic [3:0]        pc_hi_q;
  logic [PC_W-1:0]   table_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [6:0]        count_q;
  logic              err_q;

  logic              xfer;
  logic              wr_lbl_ok;
  logic              rd_lbl_ok;
  logic              wr_en;
  logic              set_err;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [11:0]       frame_pc;
  logic [PC_W-1:0]   wr_pc;

  assign in_ready  = (state != S_DONE);
  assign load_done = (state == S_DONE);
  assign xfer      = in_valid & in_ready;

  assign wr_lbl_ok = (int'(label_q) < ENTRIES);
  assign rd_lbl_ok = (int'(label) < ENTRIES);
  assign wr_idx    = label_q[IDX_W-1:0];
  assign rd_idx    = label[IDX_W-1:0];
  assign frame_pc  = {pc_hi_q, in_data};
  assign wr_pc     = PC_W'(frame_pc);

  // Clear and reset both suppress the write so a dropped byte never lands in the table.
  assign wr_en   = xfer && (state == S_LO) && wr_lbl_ok && !clear && !reset;
  // Errors: out-of-range label at frame end, or in_last arriving mid-frame.
  assign set_err = xfer && (((state == S_LO) && !wr_lbl_ok) ||
                            (((state == S_LABEL) || (state == S_HI)) && in_last));

  // Read-before-write: the table register updates on the edge, so a same-cycle
  // lookup of the label being written still sees the old contents.
  assign next_pc     = (rd_lbl_ok && valid_q[rd_idx]) ? table_q[rd_idx] : '0;
  assign err         = err_q;
  assign entry_count = count_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_LABEL: if (xfer) state_nxt = in_last ? S_DONE : S_HI;
      S_HI:    if (xfer) state_nxt = in_last ? S_DONE : S_LO;
      S_LO:    if (xfer) state_nxt = in_last ? S_DONE : S_LABEL;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_LABEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LABEL;
    end else if (clear) begin
      state <= S_LABEL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        if (count_q != 7'd127) count_q <= count_q + 7'd1;
      end
      if (set_err) err_q <= 1'b1;
    end
  end

  // Frame holding registers and table data carry no reset; valid_q gates every read.
  always_ff @(posedge clk) begin
    if (xfer && (state == S_LABEL)) label_q <= in_data;
    if (xfer && (state == S_HI))    pc_hi_q <= in_data[3:0];
    if (wr_en)                      table_q[wr_idx] <= wr_pc;
  end

endmodule

// File: tb/tb_lut_loader.sv
// Directed bench for lut_loader: stimulus pushes expected outputs, a negedge monitor pops and compares.
// Latency: expectations are sampled mid-cycle, after the edge that caused them.
// Backpressure: byte sends wait (bounded) on in_ready with random idle gaps before each byte.
module tb_lut_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  label;
  logic [11:0] next_pc;
  logic        load_done;
  logic        err;
  logic [6:0]  entry_count;

  always #5 clk = ~clk;

  lut_loader #(.ENTRIES(64), .PC_W(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .label       (label),
    .next_pc     (next_pc),
    .load_done   (load_done),
    .err         (err),
    .entry_count (entry_count)
  );

  typedef struct packed {
    logic [11:0] pc;
    logic        done;
    logic        rdy;
    logic        e;
    logic [6:0]  cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    n_timeouts = 0;
  int    stall_max = 2;

  task automatic expect_out(input string nm, input logic [11:0] pc, input logic done,
                            input logic rdy, input logic e, input logic [6:0] cnt);
    exp_t x;
    x.pc = pc; x.done = done; x.rdy = rdy; x.e = e; x.cnt = cnt;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  // Monitor: compares every pending expectation against the outputs mid-cycle.
  initial begin
    int    to_seen;
    exp_t  x;
    string nm;
    to_seen = 0;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        x  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (next_pc !== x.pc || load_done !== x.done || in_ready !== x.rdy ||
            err !== x.e || entry_count !== x.cnt) begin
          n_fail++;
          $display("FAIL %s: got next_pc=%0d load_done=%b in_ready=%b err=%b entry_count=%0d, want next_pc=%0d load_done=%b in_ready=%b err=%b entry_count=%0d",
                   nm, next_pc, load_done, in_ready, err, entry_count,
                   x.pc, x.done, x.rdy, x.e, x.cnt);
        end
      end
      if (n_timeouts != to_seen) begin
        n_cmp++;
        n_fail++;
        $display("FAIL handshake_timeout: got %0d in_ready timeouts, want 0", n_timeouts);
        to_seen = n_timeouts;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int budget;
    repeat ($urandom_range(0, stall_max)) tick();
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    budget   = 20;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!in_ready) n_timeouts++;
    else tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic frame(input logic [7:0] l, input logic [7:0] hi, input logic [7:0] lo,
                       input logic last);
    send(l, 1'b0);
    send(hi, 1'b0);
    send(lo, last);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int budget;
    reset = 1'b1; clear = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; label = 8'd0;
    repeat (3) tick();
    reset = 1'b0;
    expect_out("reset_state", 12'd0, 1'b0, 1'b1, 1'b0, 7'd0);
    tick();

    // Single frame ending the load.
    frame(8'h02, 8'h01, 8'h5B, 1'b1);
    label = 8'd2;
    expect_out("first_load_done", 12'd347, 1'b1, 1'b0, 1'b0, 7'd1);
    tick();
    pulse_clear();
    expect_out("clear_after_done", 12'd0, 1'b0, 1'b1, 1'b0, 7'd0);
    tick();

    // Two entries, hits and misses.
    frame(8'h12, 8'h00, 8'h08, 1'b0);
    frame(8'h2B, 8'h01, 8'hBD, 1'b0);
    label = 8'd18;  expect_out("lookup_18", 12'd8, 1'b0, 1'b1, 1'b0, 7'd2);   tick();
    label = 8'd43;  expect_out("lookup_43", 12'd445, 1'b0, 1'b1, 1'b0, 7'd2); tick();
    label = 8'd44;  expect_out("lookup_44_miss", 12'd0, 1'b0, 1'b1, 1'b0, 7'd2); tick();
    label = 8'd200; expect_out("lookup_200_oob", 12'd0, 1'b0, 1'b1, 1'b0, 7'd2); tick();

    // Out-of-range label frame.
    frame(8'h80, 8'hFA, 8'hAA, 1'b0);
    label = 8'h80;  expect_out("bad_label_err", 12'd0, 1'b0, 1'b1, 1'b1, 7'd2); tick();
    label = 8'd18;  expect_out("bad_label_keeps_18", 12'd8, 1'b0, 1'b1, 1'b1, 7'd2); tick();

    // Table edge: last legal label and first illegal one; upper nibble of byte1 ignored.
    pulse_clear();
    frame(8'h3F, 8'hFF, 8'hFF, 1'b0);
    label = 8'd63;  expect_out("label_63_max", 12'd4095, 1'b0, 1'b1, 1'b0, 7'd1); tick();
    frame(8'h40, 8'h01, 8'h23, 1'b0);
    label = 8'd64;  expect_out("label_64_rejected", 12'd0, 1'b0, 1'b1, 1'b1, 7'd1); tick();

    // in_last mid-frame.
    pulse_clear();
    send(8'h07, 1'b0);
    send(8'h01, 1'b1);
    label = 8'd7;   expect_out("short_frame_err", 12'd0, 1'b1, 1'b0, 1'b1, 7'd0); tick();
    pulse_clear();
    expect_out("clear_after_err", 12'd0, 1'b0, 1'b1, 1'b0, 7'd0);
    tick();

    // Rewrite with the lookup held on the same label.
    label = 8'd5;
    frame(8'h05, 8'hF0, 8'hE2, 1'b0);
    expect_out("rewrite_first", 12'd226, 1'b0, 1'b1, 1'b0, 7'd1);
    tick();
    send(8'h05, 1'b0);
    send(8'h00, 1'b0);
    in_data = 8'h64; in_last = 1'b0; in_valid = 1'b1;
    expect_out("same_cycle_old_value", 12'd226, 1'b0, 1'b1, 1'b0, 7'd1);
    tick();
    in_valid = 1'b0;
    expect_out("rewrite_new_value", 12'd100, 1'b0, 1'b1, 1'b0, 7'd2);
    tick();

    // Counter saturation: 130 writes to label 1, last pc = 129.
    pulse_clear();
    stall_max = 0;
    for (int i = 0; i < 130; i++) frame(8'h01, 8'h00, 8'(i), 1'b0);
    stall_max = 2;
    label = 8'd1;
    expect_out("count_saturates", 12'd129, 1'b0, 1'b1, 1'b0, 7'd127);
    tick();

    // Reset mid-frame abandons it; FSM restarts at the label byte.
    pulse_clear();
    send(8'h09, 1'b0);
    send(8'h03, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    label = 8'd9;
    expect_out("reset_mid_frame", 12'd0, 1'b0, 1'b1, 1'b0, 7'd0);
    tick();
    frame(8'h09, 8'h03, 8'h33, 1'b0);
    expect_out("after_reset_frame", 12'd819, 1'b0, 1'b1, 1'b0, 7'd1);
    tick();

    budget = 50;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) n_timeouts++;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
